// File: rtl/uart_text_writer_if.sv
// Byte-in / character-buffer-write bundle between the UART receiver, the text writer
// and the character buffer it fills.
interface uart_text_writer_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  wr_i;
  logic [7:0]            data_i;
  logic                  buf_we_o;
  logic [ADDR_WIDTH-1:0] buf_addr_o;
  logic [7:0]            buf_data_o;
  logic [6:0]            cursor_col_o;
  logic [4:0]            cursor_row_o;
  logic                  busy_o;
  logic                  drop_o;

  modport master (
    output wr_i, data_i,
    input  buf_we_o, buf_addr_o, buf_data_o, cursor_col_o, cursor_row_o, busy_o, drop_o
  );

  modport slave (
    input  wr_i, data_i,
    output buf_we_o, buf_addr_o, buf_data_o, cursor_col_o, cursor_row_o, busy_o, drop_o
  );
endinterface

// File: rtl/uart_text_writer.sv
// Turns received UART bytes into character-buffer writes, tracking the cursor,
// handling CR/LF/BS and sweeping the whole screen with FILL_CHAR on form feed.
module uart_text_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
  input  logic clk_i,
  input  logic rstn_i,
  uart_text_writer_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [6:0]            LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]            LAST_ROW  = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t                state;
  logic                  wr_q;
  logic                  accept;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            data;
  logic [6:0]            col;
  logic [4:0]            row;
  logic                  busy;
  logic                  drop;

  function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
    logic [ADDR_WIDTH-1:0] rw;
    logic [ADDR_WIDTH-1:0] cw;
    rw = ADDR_WIDTH'(r);
    cw = ADDR_WIDTH'(c);
    return rw * ADDR_WIDTH'(COLS) + cw;
  endfunction

  function automatic logic [4:0] next_row(input logic [4:0] r);
    return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
  endfunction

  // One byte per rising edge of the receiver's level-style valid.
  assign accept = bus.wr_i & ~wr_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      wr_q  <= 1'b1;
      we    <= 1'b0;
      addr  <= '0;
      data  <= 8'h00;
      col   <= 7'd0;
      row   <= 5'd0;
      busy  <= 1'b0;
      drop  <= 1'b0;
    end else begin
      wr_q <= bus.wr_i;
      drop <= 1'b0;
      case (state)
        IDLE: begin
          we <= 1'b0;
          if (accept) begin
            if (bus.data_i inside {[8'h20:8'h7E]}) begin
              we    <= 1'b1;
              addr  <= cell_addr(row, col);
              data  <= bus.data_i;
              state <= WRITE;
              if (col == LAST_COL) begin
                col <= 7'd0;
                row <= next_row(row);
              end else begin
                col <= col + 7'd1;
              end
            end else begin
              case (bus.data_i)
                8'h0D: col <= 7'd0;
                8'h0A: row <= next_row(row);
                8'h08: begin
                  if (col != 7'd0) begin
                    col   <= col - 7'd1;
                    we    <= 1'b1;
                    addr  <= cell_addr(row, col - 7'd1);
                    data  <= FILL_CHAR;
                    state <= WRITE;
                  end
                end
                8'h0C: begin
                  we    <= 1'b1;
                  addr  <= '0;
                  data  <= FILL_CHAR;
                  busy  <= 1'b1;
                  state <= CLEAR;
                end
                default: ;
              endcase
            end
          end
        end
        WRITE: begin
          we    <= 1'b0;
          state <= IDLE;
        end
        // The address register doubles as the sweep counter.
        CLEAR: begin
          if (accept) drop <= 1'b1;
          if (addr == LAST_ADDR) begin
            we    <= 1'b0;
            busy  <= 1'b0;
            col   <= 7'd0;
            row   <= 5'd0;
            state <= IDLE;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.buf_we_o     = we;
  assign bus.buf_addr_o   = addr;
  assign bus.buf_data_o   = data;
  assign bus.cursor_col_o = col;
  assign bus.cursor_row_o = row;
  assign bus.busy_o       = busy;
  assign bus.drop_o       = drop;

endmodule

// File: tb/tb_uart_text_writer.sv
// Randomised scoreboard bench for uart_text_writer: expected buffer writes are queued
// from a linear-position screen model and popped by a monitor on every write strobe.
module tb_uart_text_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  typedef struct {
    int         addr;
    logic [7:0] data;
    logic       busy;
  } wr_t;

  logic clk = 1'b0;
  logic rstn;

  uart_text_writer_if #(.ADDR_WIDTH(12)) bus ();

  uart_text_writer #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(12), .FILL_CHAR(8'h20)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  assert_count = 0;
  int  fail_count   = 0;
  int  drop_seen    = 0;
  int  drop_exp     = 0;
  int  m_row        = 0;
  int  m_col        = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (bus.drop_o) drop_seen++;
    if (bus.buf_we_o) begin
      if (exp_q.size() == 0) begin
        assert_count++;
        fail_count++;
        $display("[TB] FAIL unexpected_write: got addr %0d data 0x%02h, expected no write",
                 bus.buf_addr_o, bus.buf_data_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("wr_addr", int'(bus.buf_addr_o), e.addr);
        checkOutput("wr_data", int'(bus.buf_data_o), int'(e.data));
        checkOutput("wr_busy", int'(bus.busy_o), int'(e.busy));
      end
    end
  end

  // Screen model in terms of a linear cursor position over a wrapping screen.
  task automatic modelByte(input logic [7:0] b);
    int pos;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back('{m_row * COLS + m_col, b, 1'b0});
      pos   = (m_row * COLS + m_col + 1) % CELLS;
      m_row = pos / COLS;
      m_col = pos % COLS;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back('{m_row * COLS + m_col, 8'h20, 1'b0});
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) exp_q.push_back('{i, 8'h20, 1'b1});
      m_row = 0;
      m_col = 0;
    end
  endtask

  task automatic waitNotBusy();
    int n = 0;
    while (bus.busy_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) checkOutput("clear_timeout", n, 0);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    modelByte(b);
    @(negedge clk);
    bus.data_i = b;
    bus.wr_i   = 1'b1;
    repeat (3) @(negedge clk);
    bus.wr_i = 1'b0;
    if (b == 8'h0C) waitNotBusy();
    repeat (3) @(negedge clk);
    checkOutput("cursor_col", int'(bus.cursor_col_o), m_col);
    checkOutput("cursor_row", int'(bus.cursor_row_o), m_row);
  endtask

  function automatic logic [7:0] randomByte();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      6:       return 8'h0D;
      7:       return 8'h0A;
      8:       return 8'h08;
      9:       return 8'($urandom_range(127, 255));
      default: return 8'($urandom_range(32, 126));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rstn        = 1'b0;
    bus.wr_i    = 1'b1;
    bus.data_i  = 8'h41;
    repeat (3) @(negedge clk);
    checkOutput("rst_we",   int'(bus.buf_we_o), 0);
    checkOutput("rst_addr", int'(bus.buf_addr_o), 0);
    checkOutput("rst_data", int'(bus.buf_data_o), 0);
    checkOutput("rst_col",  int'(bus.cursor_col_o), 0);
    checkOutput("rst_row",  int'(bus.cursor_row_o), 0);
    checkOutput("rst_busy", int'(bus.busy_o), 0);
    checkOutput("rst_drop", int'(bus.drop_o), 0);

    // Level already high at reset release must not produce a byte.
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    bus.wr_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] first byte latency");
    modelByte(8'h41);
    bus.data_i = 8'h41;
    bus.wr_i   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat_we",   int'(bus.buf_we_o), 1);
    checkOutput("lat_addr", int'(bus.buf_addr_o), 0);
    checkOutput("lat_data", int'(bus.buf_data_o), 8'h41);
    checkOutput("lat_col",  int'(bus.cursor_col_o), 1);
    repeat (3) @(negedge clk);
    bus.wr_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] row fill and full-screen wrap");
    applyStimulus(8'h08);
    for (int i = 0; i < COLS; i++) applyStimulus(8'(8'h20 + (i % 95)));
    checkOutput("fill80_row", int'(bus.cursor_row_o), 1);
    checkOutput("fill80_col", int'(bus.cursor_col_o), 0);
    applyStimulus(8'h0C);
    for (int i = 0; i < CELLS; i++) applyStimulus(8'($urandom_range(32, 126)));
    checkOutput("wrap_row", int'(bus.cursor_row_o), 0);
    checkOutput("wrap_col", int'(bus.cursor_col_o), 0);

    $display("[TB] control characters");
    applyStimulus(8'h0C);
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h0D);
    applyStimulus(8'h0A);
    applyStimulus(8'h43);
    checkOutput("crlf_row", int'(bus.cursor_row_o), 1);
    checkOutput("crlf_col", int'(bus.cursor_col_o), 1);
    for (int i = 0; i < 28; i++) applyStimulus(8'h0A);
    checkOutput("lf_row29", int'(bus.cursor_row_o), 29);
    applyStimulus(8'h0A);
    checkOutput("lf_wrap_row", int'(bus.cursor_row_o), 0);
    checkOutput("lf_wrap_col", int'(bus.cursor_col_o), 1);

    $display("[TB] backspace");
    applyStimulus(8'h0C);
    for (int i = 0; i < 5; i++) applyStimulus(8'h61);
    applyStimulus(8'h08);
    checkOutput("bs_col", int'(bus.cursor_col_o), 4);
    applyStimulus(8'h0D);
    for (int i = 0; i < 3; i++) applyStimulus(8'h0A);
    applyStimulus(8'h08);
    checkOutput("bs0_row", int'(bus.cursor_row_o), 3);
    checkOutput("bs0_col", int'(bus.cursor_col_o), 0);

    $display("[TB] clear with a byte arriving mid-sweep");
    modelByte(8'h0C);
    @(negedge clk);
    bus.data_i = 8'h0C;
    bus.wr_i   = 1'b1;
    repeat (3) @(negedge clk);
    bus.wr_i = 1'b0;
    repeat (1000) @(negedge clk);
    checkOutput("mid_busy", int'(bus.busy_o), 1);
    drop_exp++;
    bus.data_i = 8'h5A;
    bus.wr_i   = 1'b1;
    repeat (3) @(negedge clk);
    bus.wr_i = 1'b0;
    waitNotBusy();
    repeat (2) @(negedge clk);
    checkOutput("drop_count", drop_seen, drop_exp);
    checkOutput("clr_col", int'(bus.cursor_col_o), 0);
    checkOutput("clr_row", int'(bus.cursor_row_o), 0);

    $display("[TB] random bytes");
    for (int i = 0; i < 300; i++) applyStimulus(randomByte());

    $display("[TB] reset during clear");
    modelByte(8'h0C);
    @(negedge clk);
    bus.data_i = 8'h0C;
    bus.wr_i   = 1'b1;
    repeat (3) @(negedge clk);
    bus.wr_i = 1'b0;
    n = 0;
    while (!(bus.busy_o && bus.buf_addr_o == 12'd1000) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) checkOutput("addr1000_timeout", n, 0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("abort_we",   int'(bus.buf_we_o), 0);
    checkOutput("abort_busy", int'(bus.busy_o), 0);
    checkOutput("abort_col",  int'(bus.cursor_col_o), 0);
    checkOutput("abort_row",  int'(bus.cursor_row_o), 0);
    repeat (3) @(negedge clk);
    applyStimulus(8'h51);

    repeat (5) @(negedge clk);
    checkOutput("pending_writes", exp_q.size(), 0);
    checkOutput("final_drops", drop_seen, drop_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
